// File: rtl/axi_stream_strip_header.sv
// AXI-Stream header stripper: drops a per-packet header of 1..DATA_BYTE_WD bytes
// and re-packs the remaining payload MSB-first, with a registered output stage.
module axi_stream_strip_header #(
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD / 8,
    parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    valid_in,
    input  logic [DATA_WD-1:0]      data_in,
    input  logic [DATA_BYTE_WD-1:0] keep_in,
    input  logic                    last_in,
    output logic                    ready_in,
    output logic                    valid_out,
    output logic [DATA_WD-1:0]      data_out,
    output logic [DATA_BYTE_WD-1:0] keep_out,
    output logic                    last_out,
    input  logic                    ready_out,
    input  logic                    valid_strip,
    input  logic [BYTE_CNT_WD-1:0]  byte_strip_cnt,
    output logic                    ready_strip
);

    localparam int CW = BYTE_CNT_WD + 1;
    localparam logic [CW-1:0] W_CNT = CW'(DATA_BYTE_WD);

    typedef enum logic [1:0] {IDLE, FIRST, STREAM, FLUSH} state_t;

    state_t                    state, state_nxt;
    logic [CW-1:0]             strip_len, strip_len_nxt;
    logic [CW-1:0]             res_len, res_len_nxt;
    logic [DATA_WD-1:0]        res_data, res_data_nxt;
    logic [DATA_WD-1:0]        data_m;
    logic [CW-1:0]             k_len, tot_len;
    logic                      slot_free, in_fire, strip_fire, first_has, tot_over;
    logic                      load, beat_last;
    logic [DATA_WD-1:0]        beat_data;
    logic [DATA_BYTE_WD-1:0]   beat_keep;

    function automatic logic [DATA_BYTE_WD-1:0] keep_of(input logic [CW-1:0] n);
        keep_of = ~({DATA_BYTE_WD{1'b1}} >> n);
    endfunction

    assign slot_free  = ~valid_out | ready_out;
    assign in_fire    = valid_in & ready_in;
    assign strip_fire = valid_strip & ready_strip;
    assign tot_len    = res_len + k_len;
    assign first_has  = k_len > strip_len;
    assign tot_over   = tot_len > W_CNT;

    // Null bytes are zeroed up front so every shifted product carries zero fill.
    always_comb begin
        data_m = '0;
        k_len  = '0;
        for (int unsigned i = 0; i < DATA_BYTE_WD; i++) begin
            data_m[i*8 +: 8] = {8{keep_in[i]}} & data_in[i*8 +: 8];
            k_len            = k_len + CW'(keep_in[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (strip_fire) state_nxt = FIRST;
            FIRST:   if (in_fire) state_nxt = last_in ? IDLE : STREAM;
            STREAM:  if (in_fire && last_in) state_nxt = tot_over ? FLUSH : IDLE;
            FLUSH:   if (slot_free) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ready_in    = ((state == FIRST) || (state == STREAM)) && slot_free;
        ready_strip = (state == IDLE) && slot_free;
    end

    // Residual is held left-justified; res_len stays constant through STREAM.
    always_comb begin
        load          = 1'b0;
        beat_data     = res_data | (data_m >> {res_len, 3'b000});
        beat_keep     = '1;
        beat_last     = 1'b0;
        res_data_nxt  = res_data;
        res_len_nxt   = res_len;
        strip_len_nxt = strip_len;
        unique case (state)
            IDLE: if (strip_fire) begin
                strip_len_nxt = CW'(byte_strip_cnt) + CW'(1);
                res_data_nxt  = '0;
                res_len_nxt   = '0;
            end
            FIRST: if (in_fire) begin
                res_data_nxt = data_m << {strip_len, 3'b000};
                res_len_nxt  = first_has ? (k_len - strip_len) : '0;
                if (last_in && first_has) begin
                    load      = 1'b1;
                    beat_data = res_data_nxt;
                    beat_keep = keep_of(res_len_nxt);
                    beat_last = 1'b1;
                end
            end
            STREAM: if (in_fire) begin
                load         = 1'b1;
                res_data_nxt = data_m << {W_CNT - res_len, 3'b000};
                if (last_in) begin
                    if (tot_over) begin
                        res_len_nxt = tot_len - W_CNT;
                    end else begin
                        beat_keep = keep_of(tot_len);
                        beat_last = 1'b1;
                    end
                end
            end
            FLUSH: if (slot_free) begin
                load      = 1'b1;
                beat_data = res_data;
                beat_keep = keep_of(res_len);
                beat_last = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_out <= 1'b0;
            data_out  <= '0;
            keep_out  <= '0;
            last_out  <= 1'b0;
            strip_len <= '0;
            res_len   <= '0;
            res_data  <= '0;
        end else begin
            strip_len <= strip_len_nxt;
            res_len   <= res_len_nxt;
            res_data  <= res_data_nxt;
            if (load) begin
                valid_out <= 1'b1;
                data_out  <= beat_data;
                keep_out  <= beat_keep;
                last_out  <= beat_last;
            end else if (ready_out) begin
                valid_out <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_axi_stream_strip_header.sv
// Self-checking bench for axi_stream_strip_header: byte-level reference model,
// per-cycle output scoreboard, stall-stability checks and a mid-packet reset.
module tb_axi_stream_strip_header;

    localparam int DW = 32;
    localparam int W  = DW / 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          valid_in = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic [W-1:0]  keep_in = '0;
    logic          last_in = 1'b0;
    logic          ready_in;
    logic          valid_out;
    logic [DW-1:0] data_out;
    logic [W-1:0]  keep_out;
    logic          last_out;
    logic          ready_out = 1'b1;
    logic          valid_strip = 1'b0;
    logic [1:0]    byte_strip_cnt = '0;
    logic          ready_strip;

    axi_stream_strip_header #(.DATA_WD(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .valid_in(valid_in), .data_in(data_in), .keep_in(keep_in), .last_in(last_in),
        .ready_in(ready_in),
        .valid_out(valid_out), .data_out(data_out), .keep_out(keep_out), .last_out(last_out),
        .ready_out(ready_out),
        .valid_strip(valid_strip), .byte_strip_cnt(byte_strip_cnt), .ready_strip(ready_strip)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [W-1:0]  k;
        logic          l;
    } beat_t;

    int          n_vec = 0;
    int          n_err = 0;
    logic [7:0]  pkt[$];
    beat_t       mdl_q[$];
    beat_t       exp_q[$];
    bit          rnd_ready = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Output = packet bytes after the header, chopped into W-byte beats.
    function automatic void run_model(input int s);
        int    n;
        int    i;
        beat_t b;
        mdl_q.delete();
        n = pkt.size();
        i = s;
        while (i < n) begin
            b = '0;
            for (int j = 0; j < W; j++) begin
                if (i + j < n) begin
                    b.d[DW-1-8*j -: 8] = pkt[i+j];
                    b.k[W-1-j] = 1'b1;
                end
            end
            b.l = (i + W >= n);
            mdl_q.push_back(b);
            i += W;
        end
    endfunction

    always @(posedge clk) begin
        #1;
        ready_out = rnd_ready ? 1'($urandom % 2) : 1'b1;
    end

    bit    hold_v = 1'b0;
    beat_t hold_b;
    beat_t act_b;
    always @(negedge clk) begin
        if (!rst_n) begin
            hold_v = 1'b0;
        end else begin
            act_b = '{d: data_out, k: keep_out, l: last_out};
            if (hold_v) chk("stall_hold", {27'b0, valid_out, act_b}, {27'b0, 1'b1, hold_b});
            hold_v = 1'b0;
            if (valid_out) begin
                if (ready_out) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_beat", {27'b0, act_b}, 64'hFFFF_FFFF_FFFF_FFFF);
                    end else begin
                        chk("out_beat", {27'b0, act_b}, {27'b0, exp_q.pop_front()});
                    end
                end else begin
                    hold_v = 1'b1;
                    hold_b = act_b;
                end
            end
        end
    end

    task automatic send_desc(input int s);
        int t;
        valid_strip = 1'b1;
        byte_strip_cnt = 2'(s - 1);
        t = 0;
        @(negedge clk);
        while (!ready_strip && t < 200) begin @(negedge clk); t++; end
        chk("desc_handshake", {63'b0, ready_strip}, 64'd1);
        @(posedge clk); #1;
        valid_strip = 1'b0;
    endtask

    task automatic send_beat(input int bi);
        logic [DW-1:0] d;
        logic [W-1:0]  k;
        int t;
        int n;
        n = pkt.size();
        d = $urandom;
        k = '0;
        for (int j = 0; j < W; j++) begin
            if (bi * W + j < n) begin
                d[DW-1-8*j -: 8] = pkt[bi*W+j];
                k[W-1-j] = 1'b1;
            end
        end
        valid_in = 1'b1; data_in = d; keep_in = k; last_in = (bi * W + W >= n);
        t = 0;
        @(negedge clk);
        while (!ready_in && t < 200) begin @(negedge clk); t++; end
        chk("in_handshake", {63'b0, ready_in}, 64'd1);
        @(posedge clk); #1;
        valid_in = 1'b0; last_in = 1'b0;
    endtask

    task automatic send_pkt(input int s, input bit gaps);
        int nb;
        nb = (pkt.size() + W - 1) / W;
        send_desc(s);
        for (int bi = 0; bi < nb; bi++) begin
            send_beat(bi);
            if (gaps) repeat ($urandom_range(0, 1)) begin @(posedge clk); #1; end
        end
    endtask

    task automatic drain(input string nm);
        int t;
        t = 0;
        while (exp_q.size() > 0 && t < 500) begin @(negedge clk); t++; end
        chk(nm, 64'(exp_q.size()), 64'd0);
        @(posedge clk); #1;
    endtask

    task automatic load_pkt(input logic [63:0] bytes, input int n);
        pkt.delete();
        for (int i = 0; i < n; i++) pkt.push_back(bytes[63-8*i -: 8]);
    endtask

    task automatic push_model;
        foreach (mdl_q[i]) exp_q.push_back(mdl_q[i]);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_valid_out", {63'b0, valid_out}, 64'd0);
        chk("rst_data_out", 64'(data_out), 64'd0);
        chk("rst_keep_out", 64'(keep_out), 64'd0);
        chk("rst_last_out", {63'b0, last_out}, 64'd0);
        chk("rst_ready_in", {63'b0, ready_in}, 64'd0);
        chk("rst_ready_strip", {63'b0, ready_strip}, 64'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        load_pkt(64'hAABBCCDD_11220000, 6);
        run_model(2);
        chk("mdl1_size", 64'(mdl_q.size()), 64'd1);
        chk("mdl1_b0", {27'b0, mdl_q[0]}, {27'b0, 32'hCCDD1122, 4'b1111, 1'b1});
        push_model();
        send_pkt(2, 1'b0);
        drain("drain_t1");

        load_pkt(64'hAABBCCDD_11223344, 8);
        run_model(1);
        chk("mdl2_size", 64'(mdl_q.size()), 64'd2);
        chk("mdl2_b0", {27'b0, mdl_q[0]}, {27'b0, 32'hBBCCDD11, 4'b1111, 1'b0});
        chk("mdl2_b1", {27'b0, mdl_q[1]}, {27'b0, 32'h22334400, 4'b1110, 1'b1});
        push_model();
        send_pkt(1, 1'b0);
        drain("drain_t2");

        load_pkt(64'hAABBCCDD_11223344, 8);
        run_model(4);
        chk("mdl3_size", 64'(mdl_q.size()), 64'd1);
        chk("mdl3_b0", {27'b0, mdl_q[0]}, {27'b0, 32'h11223344, 4'b1111, 1'b1});
        push_model();
        send_pkt(4, 1'b0);
        drain("drain_t3");

        load_pkt(64'hAABB0000_00000000, 2);
        run_model(2);
        chk("mdl4_size", 64'(mdl_q.size()), 64'd0);
        send_pkt(2, 1'b0);
        @(negedge clk);
        chk("t4_ready_strip", {63'b0, ready_strip}, 64'd1);
        chk("t4_no_output", {63'b0, valid_out}, 64'd0);
        drain("drain_t4");

        rnd_ready = 1'b1;
        for (int p = 0; p < 100; p++) begin
            int s;
            int n;
            s = $urandom_range(1, W);
            n = 7 * W + $urandom_range(1, W);
            pkt.delete();
            for (int i = 0; i < n; i++) pkt.push_back(8'($urandom));
            run_model(s);
            push_model();
            send_pkt(s, 1'b1);
        end
        for (int p = 0; p < 30; p++) begin
            int s;
            int n;
            s = $urandom_range(1, W);
            n = $urandom_range(1, 3 * W);
            pkt.delete();
            for (int i = 0; i < n; i++) pkt.push_back(8'($urandom));
            run_model(s);
            push_model();
            send_pkt(s, 1'b1);
        end
        drain("drain_random");

        rnd_ready = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        pkt.delete();
        for (int i = 0; i < 8 * W; i++) pkt.push_back(8'($urandom));
        run_model(2);
        push_model();
        send_desc(2);
        for (int bi = 0; bi < 3; bi++) send_beat(bi);
        rst_n = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("midrst_valid_out", {63'b0, valid_out}, 64'd0);
        chk("midrst_ready_strip", {63'b0, ready_strip}, 64'd1);
        chk("midrst_ready_in", {63'b0, ready_in}, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        pkt.delete();
        for (int i = 0; i < 3 * W + 2; i++) pkt.push_back(8'($urandom));
        run_model(3);
        push_model();
        send_pkt(3, 1'b0);
        drain("drain_after_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
